// File: rtl/cyclic_7_4_serial_encoder_if.sv
// Message handshake and serial codeword line between upstream, the encoder and the decoder.
// With ERROR_INJECT_EN defined, the bus also carries inj_en/inj_pos, sampled at acceptance.
interface cyclic_7_4_serial_encoder_if;
  logic       msg_valid;
  logic [3:0] msg_in;
  logic       msg_ready;
  logic       load;
  logic       transmitted_bit_stream;
  logic       frame_done;
`ifdef ERROR_INJECT_EN
  logic       inj_en;
  logic [2:0] inj_pos;
`endif

  modport master (
    output msg_valid,
    output msg_in,
`ifdef ERROR_INJECT_EN
    output inj_en,
    output inj_pos,
`endif
    input  msg_ready,
    input  load,
    input  transmitted_bit_stream,
    input  frame_done
  );

  modport slave (
    input  msg_valid,
    input  msg_in,
`ifdef ERROR_INJECT_EN
    input  inj_en,
    input  inj_pos,
`endif
    output msg_ready,
    output load,
    output transmitted_bit_stream,
    output frame_done
  );
endinterface

// File: rtl/cyclic_7_4_serial_encoder.sv
// Serial systematic (7,4) cyclic encoder, g(x)=1+x+x^3, codeword sent high-order first under load.
// Optional ERROR_INJECT_EN: inverts one selected codeword bit on the line for decoder exercise.
//
// state    | meaning
// S_IDLE   | msg_ready high, waiting for msg_valid
// S_DATA   | emitting m2..m0 (m3 goes out on the accepting edge), LFSR running
// S_PARITY | shifting parity p[2] out three times
// S_GAP    | load low for GAP_CYCLES cycles, frame_done in the last one
module cyclic_7_4_serial_encoder #(
  parameter int GAP_CYCLES = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  cyclic_7_4_serial_encoder_if.slave    bus
);

  localparam int CW = $clog2(GAP_CYCLES + 4);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    msg_q;
  logic [2:0]    par_q;
  logic          ready_q;
  logic          load_q;
  logic          bit_q;
  logic          done_q;
  logic [6:0]    inj_mask_q;
  logic [6:0]    inj_mask_d;
  logic [2:0]    data_idx;
  logic [2:0]    par_idx;
  logic          data_bit;

  function automatic logic [2:0] lfsr_step(input logic [2:0] p, input logic b);
    logic fb;
    fb = b ^ p[2];
    return {p[1], p[0] ^ fb, fb};
  endfunction

`ifdef ERROR_INJECT_EN
  assign inj_mask_d = (bus.inj_en && (bus.inj_pos != 3'd7)) ? (7'd1 << bus.inj_pos) : 7'd0;

  // The mask only ever touches the line; the LFSR always sees the true message bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_mask_q <= 7'd0;
    end else if (state_q == S_IDLE && ready_q && bus.msg_valid) begin
      inj_mask_q <= inj_mask_d;
    end
  end
`else
  assign inj_mask_d = 7'd0;
  assign inj_mask_q = 7'd0;
`endif

  // cnt_q counts down through the remaining bit positions of the current section
  assign data_idx = {1'b0, cnt_q[1:0]} + 3'd3;
  assign par_idx  = {1'b0, cnt_q[1:0]};
  assign data_bit = msg_q[cnt_q[1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      msg_q   <= 4'd0;
      par_q   <= 3'd0;
      ready_q <= 1'b0;
      load_q  <= 1'b0;
      bit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          load_q  <= 1'b0;
          bit_q   <= 1'b0;
          done_q  <= 1'b0;
          if (ready_q && bus.msg_valid) begin
            msg_q   <= bus.msg_in;
            par_q   <= lfsr_step(3'd0, bus.msg_in[3]);
            load_q  <= 1'b1;
            bit_q   <= bus.msg_in[3] ^ inj_mask_d[6];
            ready_q <= 1'b0;
            cnt_q   <= CW'(2);
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          bit_q <= data_bit ^ inj_mask_q[data_idx];
          par_q <= lfsr_step(par_q, data_bit);
          if (cnt_q == '0) begin
            cnt_q   <= CW'(2);
            state_q <= S_PARITY;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_PARITY: begin
          bit_q <= par_q[2] ^ inj_mask_q[par_idx];
          par_q <= {par_q[1:0], 1'b0};
          if (cnt_q == '0) begin
            cnt_q   <= CW'(GAP_CYCLES);
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_GAP: begin
          // first edge here ends the c0 cycle, so the state spans GAP_CYCLES+1 edges
          load_q <= 1'b0;
          bit_q  <= 1'b0;
          if (cnt_q == '0) begin
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            done_q <= (cnt_q == CW'(1));
            cnt_q  <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          load_q  <= 1'b0;
          bit_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.msg_ready              = ready_q;
  assign bus.load                   = load_q;
  assign bus.transmitted_bit_stream = bit_q;
  assign bus.frame_done             = done_q;

  a_ready_load_excl: assert property (@(posedge clk) disable iff (reset) !(ready_q && load_q));
  a_done_no_load:    assert property (@(posedge clk) disable iff (reset) !(done_q && load_q));

endmodule

// File: tb/tb_cyclic_7_4_serial_encoder.sv
// Directed bench for the serial (7,4) cyclic encoder with hand-computed codewords.
// Covers reset values, single frames, back-to-back framing and mid-frame reset.
module tb_cyclic_7_4_serial_encoder;
  localparam int GAP = 7;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cyclic_7_4_serial_encoder_if bus_if ();

  cyclic_7_4_serial_encoder #(.GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.msg_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_frame(input string tag, input logic [3:0] msg, input logic [6:0] exp_cw);
    bit         ok;
    logic [6:0] stream;
    logic [6:0] loadv;
    logic [GAP-1:0] donev;
    logic       frame_rdy;
    logic       gap_load;
    logic       gap_bit;
    logic       gap_rdy;
    wait_ready(ok);
    check({tag, " ready_timeout"}, 32'(ok), 32'd1);
    if (!ok) return;
    bus_if.msg_valid = 1'b1;
    bus_if.msg_in    = msg;
    @(posedge clk);
    #1;
    bus_if.msg_valid = 1'b0;
    bus_if.msg_in    = 4'h0;
    frame_rdy = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      stream[6-k] = bus_if.transmitted_bit_stream;
      loadv[6-k]  = bus_if.load;
      frame_rdy   = frame_rdy | bus_if.msg_ready;
    end
    gap_load = 1'b0;
    gap_bit  = 1'b0;
    gap_rdy  = 1'b0;
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      gap_load = gap_load | bus_if.load;
      gap_bit  = gap_bit  | bus_if.transmitted_bit_stream;
      gap_rdy  = gap_rdy  | bus_if.msg_ready;
      donev[g] = bus_if.frame_done;
    end
    check({tag, " stream"},    32'(stream),   32'(exp_cw));
    check({tag, " load"},      32'(loadv),    32'h7F);
    check({tag, " frame_rdy"}, 32'(frame_rdy), 32'd0);
    check({tag, " gap_lines"}, {29'd0, gap_load, gap_bit, gap_rdy}, 32'd0);
    check({tag, " frame_done"}, 32'(donev), 32'(1 << (GAP - 1)));
    @(negedge clk);
    check({tag, " ready_after"}, 32'(bus_if.msg_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    int         t_first;
    int         t_second;
    int         rdy_hi;
    logic       prev_load;
    logic [6:0] s2;

    reset            = 1'b1;
    bus_if.msg_valid = 1'b0;
    bus_if.msg_in    = 4'h0;
`ifdef ERROR_INJECT_EN
    bus_if.inj_en    = 1'b0;
    bus_if.inj_pos   = 3'd7;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst ready", 32'(bus_if.msg_ready), 32'd0);
    check("rst outs", {29'd0, bus_if.load, bus_if.transmitted_bit_stream, bus_if.frame_done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst ready", 32'(bus_if.msg_ready), 32'd1);

    send_frame("m1000", 4'b1000, 7'b1000101);
    send_frame("m0001", 4'b0001, 7'b0001011);
    send_frame("m1111", 4'b1111, 7'b1111111);
    send_frame("m0000", 4'b0000, 7'b0000000);
    send_frame("m0100", 4'b0100, 7'b0100111);
    send_frame("m0010", 4'b0010, 7'b0010110);
    send_frame("m1010", 4'b1010, 7'b1010011);

    // back-to-back with msg_valid held high
    wait_ready(ok);
    check("b2b ready_timeout", 32'(ok), 32'd1);
    bus_if.msg_valid = 1'b1;
    bus_if.msg_in    = 4'b1000;
    @(posedge clk);
    #1;
    bus_if.msg_in = 4'b0001;
    t_first   = -1;
    t_second  = -1;
    rdy_hi    = 0;
    prev_load = 1'b0;
    s2        = 7'd0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus_if.load && !prev_load) begin
        if (t_first < 0) t_first = c;
        else if (t_second < 0) t_second = c;
      end
      if (t_first >= 0 && c < t_first + 7 + GAP && bus_if.msg_ready) rdy_hi++;
      if (t_second >= 0 && c - t_second < 7) s2[6 - (c - t_second)] = bus_if.transmitted_bit_stream;
      prev_load = bus_if.load;
      if (bus_if.msg_ready && t_first >= 0 && bus_if.msg_valid) begin
        @(posedge clk);
        #1;
        bus_if.msg_valid = 1'b0;
        bus_if.msg_in    = 4'h0;
      end
    end
    check("b2b first_rise", 32'(t_first), 32'd0);
    check("b2b period", 32'(t_second - t_first), 32'(8 + GAP));
    check("b2b ready_low", 32'(rdy_hi), 32'd0);
    check("b2b second_stream", 32'(s2), 32'b0001011);

    // reset asserted in frame cycle 3
    wait_ready(ok);
    check("rstmid ready_timeout", 32'(ok), 32'd1);
    bus_if.msg_valid = 1'b1;
    bus_if.msg_in    = 4'b1111;
    @(posedge clk);
    #1;
    bus_if.msg_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rstmid pre_load", {30'd0, bus_if.load, bus_if.transmitted_bit_stream}, 32'd3);
    reset = 1'b1;
    #1;
    check("rstmid async_outs", {30'd0, bus_if.load, bus_if.transmitted_bit_stream}, 32'd0);
    check("rstmid ready_in_rst", 32'(bus_if.msg_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid ready_after", 32'(bus_if.msg_ready), 32'd1);
    check("rstmid no_resume", 32'(bus_if.load), 32'd0);
    send_frame("post_rst m0100", 4'b0100, 7'b0100111);

`ifdef ERROR_INJECT_EN
    bus_if.inj_en  = 1'b1;
    bus_if.inj_pos = 3'd4;
    send_frame("inj pos4", 4'b1000, 7'b1010101);
    bus_if.inj_pos = 3'd7;
    send_frame("inj pos7", 4'b1000, 7'b1000101);
    bus_if.inj_en  = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
